// File: rtl/inst_decode_if.sv
// Decode-stage bus: fetch/control/write-back inputs and the latched operands
// handed to execute.
//   master : upstream side, drives ESTADO/IR/NPC_IN/WB_*, observes decode results
//   slave  : the decode stage itself
interface inst_decode_if;
  logic [2:0]  ESTADO;    // current control-FSM state
  logic [31:0] IR;        // instruction register from fetch
  logic [15:0] NPC_IN;    // next PC from fetch
  logic        WB_EN;     // register write enable from write-back
  logic [4:0]  WB_ADDR;   // write-back destination register
  logic [31:0] WB_DATA;   // write-back data
  logic [31:0] A;         // latched rs1 operand
  logic [31:0] B;         // latched rs2 operand
  logic [31:0] IMM;       // latched sign-extended immediate
  logic [15:0] NPC_OUT;   // latched NPC forwarded to execute
  logic [5:0]  OPCODE;    // latched IR[31:26]
  logic [4:0]  RD;        // latched destination register index
  logic        ID_VALID;  // pulse the cycle after a decode latch

  modport master (
    output ESTADO, IR, NPC_IN, WB_EN, WB_ADDR, WB_DATA,
    input  A, B, IMM, NPC_OUT, OPCODE, RD, ID_VALID
  );

  modport slave (
    input  ESTADO, IR, NPC_IN, WB_EN, WB_ADDR, WB_DATA,
    output A, B, IMM, NPC_OUT, OPCODE, RD, ID_VALID
  );
endinterface

// File: rtl/inst_decode.sv
// Instruction decode stage of the multicycle processor.
// Holds the 32x32 register file (R0 hardwired to zero), reads rs1/rs2,
// sign-extends the immediate and latches A/B/IMM/NPC/OPCODE/RD for execute
// on every edge where ESTADO equals ST_ID. Write-back is independent of ESTADO.
//
// Ports:
//   CLK  - system clock, rising edge
//   RST  - synchronous active-high reset (clears outputs and all registers)
//   dec  - inst_decode_if.slave bundle (see inst_decode_if.sv)
//
// Build option:
//   WB_BYPASS_EN - when defined, a write-back landing on the same edge as a
//                  decode that reads the same register is forwarded into A/B
//                  (write-before-read). Undefined: A/B see the old value.
module inst_decode #(
  parameter logic [2:0]  ST_ID = 3'd1,
  parameter int unsigned NREGS = 32
) (
  input  logic          CLK,
  input  logic          RST,
  inst_decode_if.slave  dec
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ALEN  = 16;
  localparam int unsigned RIDX  = 5;
  localparam int unsigned OPW   = 6;
  localparam logic [OPW-1:0]  OP_RTYPE = 6'h00;
  localparam logic [OPW-1:0]  OP_J     = 6'h02;
  localparam logic [OPW-1:0]  OP_JAL   = 6'h03;
  localparam logic [RIDX-1:0] LINK_REG = 5'd31;

  // Register file
  logic [XLEN-1:0] regs [NREGS];

  // Latched stage outputs
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] imm_q;
  logic [ALEN-1:0] npc_q;
  logic [OPW-1:0]  op_q;
  logic [RIDX-1:0] rd_q;
  logic            valid_q;

  // Field extraction
  logic [OPW-1:0]  op_c;
  logic [RIDX-1:0] rs1_c;
  logic [RIDX-1:0] rs2_c;
  logic [RIDX-1:0] rdr_c;
  logic [15:0]     imm16_c;
  logic [25:0]     off26_c;

  assign op_c    = dec.IR[31:26];
  assign rs1_c   = dec.IR[25:21];
  assign rs2_c   = dec.IR[20:16];
  assign rdr_c   = dec.IR[15:11];
  assign imm16_c = dec.IR[15:0];
  assign off26_c = dec.IR[25:0];

  logic            decode_c;
  logic            wb_write_c;
  logic [XLEN-1:0] rd_a_c;
  logic [XLEN-1:0] rd_b_c;
  logic [XLEN-1:0] imm_c;
  logic [RIDX-1:0] dst_c;

  assign decode_c   = (dec.ESTADO == ST_ID);
  assign wb_write_c = dec.WB_EN && (dec.WB_ADDR != '0);

  // Operand read; index 0 always reads zero regardless of array contents
  always_comb begin
    rd_a_c = '0;
    rd_b_c = '0;
    if (rs1_c != '0) rd_a_c = regs[rs1_c];
    if (rs2_c != '0) rd_b_c = regs[rs2_c];
`ifdef WB_BYPASS_EN
    // Forward same-edge write-back so the operand sees the new value
    if (wb_write_c && (dec.WB_ADDR == rs1_c)) rd_a_c = dec.WB_DATA;
    if (wb_write_c && (dec.WB_ADDR == rs2_c)) rd_b_c = dec.WB_DATA;
`endif
  end

  // Immediate: jumps use the 26-bit offset, everything else the 16-bit field
  always_comb begin
    imm_c = {{(XLEN-16){imm16_c[15]}}, imm16_c};
    if ((op_c == OP_J) || (op_c == OP_JAL))
      imm_c = {{(XLEN-26){off26_c[25]}}, off26_c};
  end

  // Destination: R-type uses rd field, JAL links to R31, others use rs2
  always_comb begin
    dst_c = rs2_c;
    if (op_c == OP_RTYPE)   dst_c = rdr_c;
    else if (op_c == OP_JAL) dst_c = LINK_REG;
  end

  // Register file write port
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_write_c) begin
      regs[dec.WB_ADDR] <= dec.WB_DATA;
    end
  end

  // Decode latch; holds while ESTADO is elsewhere
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      npc_q   <= 16'h0000;
      op_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= decode_c;
      if (decode_c) begin
        a_q   <= rd_a_c;
        b_q   <= rd_b_c;
        imm_q <= imm_c;
        npc_q <= dec.NPC_IN;
        op_q  <= op_c;
        rd_q  <= dst_c;
      end
    end
  end

  assign dec.A        = a_q;
  assign dec.B        = b_q;
  assign dec.IMM      = imm_q;
  assign dec.NPC_OUT  = npc_q;
  assign dec.OPCODE   = op_q;
  assign dec.RD       = rd_q;
  assign dec.ID_VALID = valid_q;

endmodule

// File: tb/tb_inst_decode.sv
// Directed self-checking bench for inst_decode.
module tb_inst_decode;

  logic CLK = 1'b0;
  logic RST;
  int   total = 0;
  int   bad   = 0;

  localparam logic [2:0] ST_ID  = 3'd1;
  localparam logic [2:0] ST_OTH = 3'd2;

  inst_decode_if dec ();

  inst_decode dut (
    .CLK (CLK),
    .RST (RST),
    .dec (dec)
  );

  always #5 CLK = ~CLK;

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    dec.ESTADO  = 3'd0;
    dec.WB_EN   = 1'b1;
    dec.WB_ADDR = addr;
    dec.WB_DATA = data;
    tick();
    dec.WB_EN   = 1'b0;
  endtask

  task automatic decode(input logic [31:0] ir, input logic [15:0] npc);
    dec.ESTADO = ST_ID;
    dec.IR     = ir;
    dec.NPC_IN = npc;
    tick();
    dec.ESTADO = 3'd0;
  endtask

  logic [31:0] ir_v;
  logic [31:0] exp_a;

  initial begin
    dec.ESTADO  = ST_ID;
    dec.IR      = 32'h2064_8000;   // rs1=3, rs2=4
    dec.NPC_IN  = 16'h1234;
    dec.WB_EN   = 1'b1;
    dec.WB_ADDR = 5'd3;
    dec.WB_DATA = 32'hFFFF_FFFF;
    RST         = 1'b1;
    #1;
    tick();
    tick();

    // Reset overrides the simultaneous write-back and decode
    chk("rst_A",        dec.A, 32'h0);
    chk("rst_B",        dec.B, 32'h0);
    chk("rst_IMM",      dec.IMM, 32'h0);
    chk("rst_NPC",      32'(dec.NPC_OUT), 32'h0);
    chk("rst_OPCODE",   32'(dec.OPCODE), 32'h0);
    chk("rst_RD",       32'(dec.RD), 32'h0);
    chk("rst_ID_VALID", 32'(dec.ID_VALID), 32'h0);

    // Every register reads zero after reset; back-to-back decodes keep ID_VALID high
    RST       = 1'b0;
    dec.WB_EN = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ir_v = {6'h08, 5'(i), 5'(31 - i), 16'h0000};
      dec.ESTADO = ST_ID;
      dec.IR     = ir_v;
      tick();
      chk($sformatf("rst_reg_A%0d", i), dec.A, 32'h0);
      chk($sformatf("rst_reg_B%0d", 31 - i), dec.B, 32'h0);
      chk("consec_ID_VALID", 32'(dec.ID_VALID), 32'h1);
    end

    // Write R3/R4 then R-type decode: rs1=3 rs2=4 rd=5, imm16=0x2820
    wr(5'd3, 32'h0000_0011);
    wr(5'd4, 32'hFFFF_FFF0);
    decode(32'h0064_2820, 16'h0004);
    chk("rt_A",        dec.A, 32'h0000_0011);
    chk("rt_B",        dec.B, 32'hFFFF_FFF0);
    chk("rt_RD",       32'(dec.RD), 32'd5);
    chk("rt_OPCODE",   32'(dec.OPCODE), 32'h0);
    chk("rt_NPC",      32'(dec.NPC_OUT), 32'h0004);
    chk("rt_IMM",      dec.IMM, 32'h0000_2820);
    chk("rt_ID_VALID", 32'(dec.ID_VALID), 32'h1);
    tick();
    chk("rt_pulse_end", 32'(dec.ID_VALID), 32'h0);

    // I-type: op=8 rs1=1 rs2=2, negative imm16
    decode(32'h2022_8000, 16'h0008);
    chk("i_IMM",    dec.IMM, 32'hFFFF_8000);
    chk("i_RD",     32'(dec.RD), 32'd2);
    chk("i_OPCODE", 32'(dec.OPCODE), 32'h08);

    // JAL with positive off26
    decode(32'h0C00_0010, 16'h000C);
    chk("jal_IMM", dec.IMM, 32'h0000_0010);
    chk("jal_RD",  32'(dec.RD), 32'd31);
    // JAL 0x0E000010: off26 = 0x2000010 has bit 25 set, so it extends negative
    decode(32'h0E00_0010, 16'h000C);
    chk("jal_neg_IMM", dec.IMM, 32'hFE00_0010);
    chk("jal_neg_RD",  32'(dec.RD), 32'd31);

    // J: off26 = 0x3FFFFFC, rs2 field=31 used as RD
    decode(32'h0BFF_FFFC, 16'h0010);
    chk("j_IMM",    dec.IMM, 32'hFFFF_FFFC);
    chk("j_OPCODE", 32'(dec.OPCODE), 32'h02);
    chk("j_RD",     32'(dec.RD), 32'd31);

    // R0 write is discarded
    wr(5'd0, 32'hDEAD_BEEF);
    decode(32'h2003_0000, 16'h0014);   // rs1=0 rs2=3
    chk("r0_A", dec.A, 32'h0);
    chk("r0_B", dec.B, 32'h0000_0011);

    // R0 write on the same edge as a decode reading R0
    dec.WB_EN   = 1'b1;
    dec.WB_ADDR = 5'd0;
    dec.WB_DATA = 32'hDEAD_BEEF;
    decode(32'h2000_0000, 16'h0018);   // rs1=0 rs2=0
    dec.WB_EN   = 1'b0;
    chk("r0_same_A", dec.A, 32'h0);
    chk("r0_same_B", dec.B, 32'h0);

    // Reference decode for the hold test: op=8 rs1=4 rs2=3 imm=0x1234
    decode(32'h2083_1234, 16'h0020);
    chk("ref_A", dec.A, 32'hFFFF_FFF0);
    chk("ref_B", dec.B, 32'h0000_0011);

    // Hold: other state, changing inputs and write-backs for 5 cycles
    for (int i = 0; i < 5; i++) begin
      dec.ESTADO  = ST_OTH;
      dec.IR      = $urandom;
      dec.NPC_IN  = 16'($urandom);
      dec.WB_EN   = 1'b1;
      dec.WB_ADDR = 5'(9 + i);
      dec.WB_DATA = $urandom;
      tick();
      chk("hold_ID_VALID", 32'(dec.ID_VALID), 32'h0);
    end
    dec.WB_EN = 1'b0;
    chk("hold_A",      dec.A, 32'hFFFF_FFF0);
    chk("hold_B",      dec.B, 32'h0000_0011);
    chk("hold_IMM",    dec.IMM, 32'h0000_1234);
    chk("hold_NPC",    32'(dec.NPC_OUT), 32'h0020);
    chk("hold_RD",     32'(dec.RD), 32'd3);
    chk("hold_OPCODE", 32'(dec.OPCODE), 32'h08);

    // Write and decode to different registers on the same edge: no interaction
    dec.WB_EN   = 1'b1;
    dec.WB_ADDR = 5'd20;
    dec.WB_DATA = 32'h0000_0055;
    decode(32'h2064_0000, 16'h0024);   // rs1=3 rs2=4
    dec.WB_EN   = 1'b0;
    chk("indep_A", dec.A, 32'h0000_0011);
    chk("indep_B", dec.B, 32'hFFFF_FFF0);
    decode(32'h2280_0000, 16'h0028);   // rs1=20
    chk("indep_R20", dec.A, 32'h0000_0055);

    // Same-edge conflict on R7
    wr(5'd7, 32'h1);
    dec.WB_EN   = 1'b1;
    dec.WB_ADDR = 5'd7;
    dec.WB_DATA = 32'h9;
    decode(32'h20E0_0000, 16'h002C);   // rs1=7 rs2=0
    dec.WB_EN   = 1'b0;
`ifdef WB_BYPASS_EN
    exp_a = 32'h9;
`else
    exp_a = 32'h1;
`endif
    chk("conflict_A", dec.A, exp_a);
    chk("conflict_B", dec.B, 32'h0);
    decode(32'h20E0_0000, 16'h0030);
    chk("conflict_after_A", dec.A, 32'h9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
